dram_responder: RTL and testbench

- Memory-side responder for the pipeline's DRAM access stage.
- Accepts one load or store request at a time and models a fixed multi-cycle access latency over an internal doubleword array.
- Returns read data on dram_dout and signals completion on dram_done, which the access stage uses to gate its advance.
- dram_done is high whenever no DRAM operation is outstanding, so non-DRAM instructions are never blocked.

---
 rtl/dram_responder.sv | 109 ++++++++++
 tb/tb_dram_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// DRAM-side responder for the access stage: one load/store at a time,
// fixed per-op latency over a byte-maskable doubleword array.
module dram_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  input  logic        stall,
  output logic [63:0] dram_dout,
  output logic        dram_done,
  output logic        dram_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [63:0]             r_wdata;
  logic [7:0]              r_wmask;
  logic [63:0]             r_dout;
  logic [63:0]             r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_commit;
  logic                    w_unused_addr;

  // Offset bits and bits past the array are dropped: align down and wrap.
  assign w_idx         = req_addr[ADDR_WIDTH+2:3];
  assign w_unused_addr = ^{req_addr[63:ADDR_WIDTH+3], req_addr[2:0]};

  assign w_commit  = (r_state == BUSY) && (r_cnt == 4'd0);
  assign dram_done = ((r_state == IDLE) && !req_valid) ||
                     (r_state == RESP);
  assign dram_busy = (r_state != IDLE);
  assign dram_dout = r_dout;

  // Array is never reset; a write lands only on the final BUSY edge.
  always_ff @(posedge clk) begin
    if (w_commit && r_we) begin
      for (int i = 0; i < 8; i++) begin
        if (r_wmask[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM: accept in IDLE, count down in BUSY, hold RESP on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= 64'd0;
      r_wmask <= 8'd0;
      r_dout  <= 64'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= w_idx;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            r_cnt   <= req_we ? WR_CNT : RD_CNT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_we) begin
              r_dout <= r_mem[r_addr];
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          if (!stall) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder with a response scoreboard:
// each issued op queues the dram_dout expected when it reaches RESP.
module tb_dram_responder;

  localparam int AW  = 10;
  localparam int RDL = 3;
  localparam int WRL = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        stall;
  logic [63:0] dram_dout;
  logic        dram_done;
  logic        dram_busy;

  int checks;
  int failures;

  logic [63:0] sb_q[$];
  logic        prev_resp;

  dram_responder #(
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RDL),
    .WRITE_LATENCY(WRL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .stall    (stall),
    .dram_dout(dram_dout),
    .dram_done(dram_done),
    .dram_busy(dram_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation on each entry into RESP.
  always @(negedge clk) begin
    logic resp;
    resp = dram_busy && dram_done;
    if (reset) begin
      prev_resp = 1'b0;
    end else begin
      if (resp && !prev_resp) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_resp: got dout 0x%016h expected none",
                   dram_dout);
        end else begin
          check("sb_dout", dram_dout, sb_q.pop_front());
        end
      end
      prev_resp = resp;
    end
  end

  // Issue one op, check done timing, optionally stall in RESP.
  task automatic op(input string name, input logic we,
                    input logic [63:0] addr, input logic [63:0] wdata,
                    input logic [7:0] wmask, input int lat,
                    input int stall_cyc, input logic [63:0] exp);
    int n;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    n = 0;
    forever begin
      @(negedge clk);
      if (dram_done) break;
      n++;
      if (n > 20) break;
    end
    check({name, "_latency"}, 64'(n), 64'(lat + 1));
    req_valid = 1'b0;
    if (stall_cyc > 0) stall = 1'b1;
    for (int k = 0; k < stall_cyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_stall_done"}, 64'(dram_done), 64'd1);
      check({name, "_stall_busy"}, 64'(dram_busy), 64'd1);
      check({name, "_stall_dout"}, dram_dout, exp);
    end
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle_busy"}, 64'(dram_busy), 64'd0);
    check({name, "_idle_done"}, 64'(dram_done), 64'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_resp = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    req_wmask = 8'd0;
    stall     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_done", 64'(dram_done), 64'd1);
    check("rst_busy", 64'(dram_busy), 64'd0);
    check("rst_dout", dram_dout, 64'd0);

    op("wr40", 1'b1, 64'h40, 64'h1122334455667788, 8'hFF,
       WRL, 0, 64'd0);
    op("rd40", 1'b0, 64'h40, 64'd0, 8'h00,
       RDL, 0, 64'h1122334455667788);
    op("wr40p", 1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F,
       WRL, 0, 64'h1122334455667788);
    op("rd47", 1'b0, 64'h47, 64'd0, 8'h00,
       RDL, 0, 64'h11223344AAAAAAAA);
    op("rd40s", 1'b0, 64'h40, 64'd0, 8'h00,
       RDL, 3, 64'h11223344AAAAAAAA);
    op("wr80", 1'b1, 64'h80, 64'hDEADBEEFCAFEF00D, 8'hFF,
       WRL, 0, 64'h11223344AAAAAAAA);
    op("rd80", 1'b0, 64'h80, 64'd0, 8'h00,
       RDL, 0, 64'hDEADBEEFCAFEF00D);

    // Aborted write: reset lands in BUSY cycle 1.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 64'h80;
    req_wdata = 64'h0;
    req_wmask = 8'hFF;
    @(posedge clk);
    #1;
    check("abort_busy_pre", 64'(dram_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(dram_busy), 64'd0);
    check("abort_dout", dram_dout, 64'd0);
    check("abort_done_waiting", 64'(dram_done), 64'd0);
    req_valid = 1'b0;
    #1;
    check("abort_done_idle", 64'(dram_done), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    op("rd80b", 1'b0, 64'h80, 64'd0, 8'h00,
       RDL, 0, 64'hDEADBEEFCAFEF00D);
    op("rdwrap", 1'b0, (64'd1 << (AW + 3)) + 64'h40, 64'd0, 8'h00,
       RDL, 0, 64'h11223344AAAAAAAA);
    op("wrm0", 1'b1, 64'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00,
       WRL, 0, 64'h11223344AAAAAAAA);
    op("rd40c", 1'b0, 64'h40, 64'd0, 8'h00,
       RDL, 0, 64'h11223344AAAAAAAA);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
